hazard_ctrl: RTL and testbench

- Pipeline hazard/sequencing controller for the 5-stage core (8-bit PC, 20-bit instruction).
- Drives PC write-enable/select plus stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences load-use stalls, taken-branch flushes, multi-cycle data-memory waits and halt.
- Sits beside the forwarding unit; it consumes decoded stage fields and produces no datapath values.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_mem_wait_cnt.sv | 32 +++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  localparam int          REG_AW_DEF = 4;
  localparam logic [19:0] NOP_INSTR  = 20'h00000;

endpackage

// File: rtl/hazard_mem_wait_cnt.sv
// rtl/hazard_mem_wait_cnt.sv - loadable 4-bit down-counter with zero flag for data-memory waits.
module hazard_mem_wait_cnt (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - PC/stall/flush sequencing for load-use, branch, memory wait and halt.
// Optional HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic              id_halt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_access,
  output logic              pc_we,
  output logic              pc_sel,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_flush,
  output logic              halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam bit         WAIT_EN  = (MEM_LAT > 1);
  localparam logic [3:0] LOAD_VAL = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_e state_q, state_d;
  logic   ret_q, ret_d;
  logic   cnt_load, cnt_dec, cnt_zero;
  logic   frz, run_rules, halt_outs, load_use;
  logic   pc_we_c, pc_sel_c, ifs_c, iff_c, ids_c, idf_c, exs_c, mwf_c, halted_c;

  hazard_mem_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    frz       = 1'b0;
    run_rules = 1'b0;
    halt_outs = 1'b0;
    pc_we_c   = 1'b0;
    pc_sel_c  = 1'b0;
    ifs_c     = 1'b0;
    iff_c     = 1'b0;
    ids_c     = 1'b0;
    idf_c     = 1'b0;
    exs_c     = 1'b0;
    mwf_c     = 1'b0;
    halted_c  = (state_q == HALTED) || ((state_q == MEM_WAIT) && ret_q);

    // ret_q remembers whether the wait was entered from HALTED so it returns there.
    case (state_q)
      RUN: begin
        if (WAIT_EN && mem_access) begin
          frz      = 1'b1;
          cnt_load = 1'b1;
          ret_d    = 1'b0;
          state_d  = MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!cnt_zero) begin
          frz     = 1'b1;
          cnt_dec = 1'b1;
        end else if (ret_q) begin
          halt_outs = 1'b1;
          state_d   = HALTED;
        end else begin
          run_rules = 1'b1;
          state_d   = RUN;
        end
      end
      HALTED: begin
        if (WAIT_EN && mem_access) begin
          frz      = 1'b1;
          cnt_load = 1'b1;
          ret_d    = 1'b1;
          state_d  = MEM_WAIT;
        end else begin
          halt_outs = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (frz) begin
      ifs_c = 1'b1;
      ids_c = 1'b1;
      exs_c = 1'b1;
      mwf_c = 1'b1;
    end else if (halt_outs) begin
      ifs_c = 1'b1;
      idf_c = 1'b1;
    end else if (run_rules) begin
      if (ex_branch_taken) begin
        pc_we_c  = 1'b1;
        pc_sel_c = 1'b1;
        iff_c    = 1'b1;
        idf_c    = 1'b1;
      end else if (load_use) begin
        ifs_c = 1'b1;
        idf_c = 1'b1;
      end else if (id_halt) begin
        ifs_c   = 1'b1;
        idf_c   = 1'b1;
        state_d = HALTED;
      end else begin
        pc_we_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Every control is forced low while reset is held, including pc_we and halted.
  assign pc_we        = rstn & pc_we_c;
  assign pc_sel       = rstn & pc_sel_c;
  assign if_id_stall  = rstn & ifs_c;
  assign if_id_flush  = rstn & iff_c;
  assign id_ex_stall  = rstn & ids_c;
  assign id_ex_flush  = rstn & idf_c;
  assign ex_mem_stall = rstn & exs_c;
  assign mem_wb_flush = rstn & mwf_c;
  assign halted       = rstn & halted_c;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_we && !halted && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (if_id_flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - checks hazard_ctrl (MEM_LAT=3 and MEM_LAT=1) against a cycle model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs2, id_halt, ex_mem_read, ex_branch_taken, mem_access;

  logic [8:0] obs [2];
  logic       o_pc_we [2], o_pc_sel [2], o_ifs [2], o_iff [2], o_ids [2];
  logic       o_idf [2], o_exs [2], o_mwf [2], o_hlt [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: further frozen cycles, release-pending flag, halted flag.
  int         lat [2] = '{3, 1};
  int         frz_rem [2], n_frz_rem [2];
  bit         rel [2], n_rel [2], hlt [2], n_hlt [2];
  logic [8:0] exp_v [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(4), .MEM_LAT(3)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .pc_we(o_pc_we[0]), .pc_sel(o_pc_sel[0]), .if_id_stall(o_ifs[0]), .if_id_flush(o_iff[0]),
    .id_ex_stall(o_ids[0]), .id_ex_flush(o_idf[0]), .ex_mem_stall(o_exs[0]),
    .mem_wb_flush(o_mwf[0]), .halted(o_hlt[0])
  );

  hazard_ctrl #(.REG_AW(4), .MEM_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .pc_we(o_pc_we[1]), .pc_sel(o_pc_sel[1]), .if_id_stall(o_ifs[1]), .if_id_flush(o_iff[1]),
    .id_ex_stall(o_ids[1]), .id_ex_flush(o_idf[1]), .ex_mem_stall(o_exs[1]),
    .mem_wb_flush(o_mwf[1]), .halted(o_hlt[1])
  );

  // Bit order: pc_we pc_sel if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall mem_wb_flush halted
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      obs[k] = {o_pc_we[k], o_pc_sel[k], o_ifs[k], o_iff[k], o_ids[k], o_idf[k],
                o_exs[k], o_mwf[k], o_hlt[k]};
    end
  end

  task automatic model_eval(input int k);
    bit lu, frozen;
    n_frz_rem[k] = frz_rem[k];
    n_rel[k]     = 1'b0;
    n_hlt[k]     = hlt[k];
    if (!rstn) begin
      n_frz_rem[k] = 0;
      n_hlt[k]     = 1'b0;
      exp_v[k]     = 9'b0;
      return;
    end
    lu = ex_mem_read && (ex_rd != 0) &&
         ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
    frozen = (frz_rem[k] > 0) || (!rel[k] && mem_access && (lat[k] > 1));
    if (frozen) begin
      n_frz_rem[k] = (frz_rem[k] > 0) ? frz_rem[k] - 1 : lat[k] - 2;
      n_rel[k]     = (n_frz_rem[k] == 0);
      exp_v[k]     = {7'b0010101, 1'b1, hlt[k]};
    end else if (hlt[k]) begin
      exp_v[k] = 9'b001001001;
    end else if (ex_branch_taken) begin
      exp_v[k] = 9'b110101000;
    end else if (lu) begin
      exp_v[k] = 9'b001001000;
    end else if (id_halt) begin
      exp_v[k] = 9'b001001000;
      n_hlt[k] = 1'b1;
    end else begin
      exp_v[k] = 9'b100000000;
    end
  endtask

  task automatic step(input string tag);
    model_eval(0);
    model_eval(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      assert (obs[k] === exp_v[k]) n_pass++;
      else $error("FAIL %s lat%0d: observed %b expected %b", tag, lat[k], obs[k], exp_v[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      frz_rem[k] = n_frz_rem[k];
      rel[k]     = n_rel[k];
      hlt[k]     = n_hlt[k];
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs2 = 0; id_halt = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_access = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      frz_rem[k] = 0; rel[k] = 0; hlt[k] = 0;
    end
    rstn = 1'b0;
    idle_inputs();
    step("reset0");
    step("reset1");
    rstn = 1'b1;
    step("idle_run");
    step("idle_run2");

    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3;
    step("load_use");
    idle_inputs();
    step("load_use_done");
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    step("load_use_r0");
    ex_rd = 5; id_rs1 = 1; id_rs2 = 5; id_use_rs2 = 0;
    step("rs2_unused");
    id_use_rs2 = 1;
    step("rs2_hit");
    idle_inputs();

    mem_access = 1;
    step("mem_frz1");
    step("mem_frz2");
    step("mem_release");
    mem_access = 0;
    step("mem_after");

    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 2; id_rs1 = 2; id_halt = 1;
    step("branch_over_lu");
    mem_access = 1;
    step("br_mem_frz1");
    step("br_mem_frz2");
    step("br_mem_flush");
    idle_inputs();
    step("br_done");

    for (int i = 0; i < 400; i++) begin
      rstn            = ($urandom_range(0, 39) != 0);
      id_rs1          = 4'($urandom_range(0, 3));
      id_rs2          = 4'($urandom_range(0, 3));
      ex_rd           = 4'($urandom_range(0, 3));
      id_use_rs2      = 1'($urandom);
      ex_mem_read     = 1'($urandom);
      id_halt         = ($urandom_range(0, 24) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_access      = ($urandom_range(0, 6) == 0);
      step("random");
    end

    rstn = 1'b0;
    idle_inputs();
    step("pre_halt_reset");
    rstn = 1'b1;
    id_halt = 1;
    step("halt_issue");
    id_halt = 0;
    step("halted1");
    step("halted2");
    mem_access = 1;
    step("halt_frz1");
    step("halt_frz2");
    step("halt_release");
    mem_access = 0;
    step("halted3");
    rstn = 1'b0;
    step("halt_reset");
    rstn = 1'b1;
    step("halt_cleared");

    mem_access = 1;
    step("wait_entry");
    rstn = 1'b0;
    step("reset_mid_wait");
    rstn = 1'b1;
    mem_access = 0;
    step("post_wait_reset");
    step("post_wait_reset2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
